// File: rtl/linked_list_arbiter_if.sv
// Request/response and list-engine bus of the linked-list arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req_valid until their req_ready pulse.
//
// Ports (signals of the bundle):
//   req_valid/req_lock/req_op/req_addr/req_data : packed per-requester request, requester i at slice i
//   req_ready                                   : one-hot accept pulse
//   resp_valid/resp_id/resp_data/resp_fault     : one-cycle tagged response
//   ll_op/ll_addr/ll_data/ll_op_start           : command to the list engine
//   ll_op_done/ll_data_out/ll_fault             : completion from the list engine
//   busy/wdog_err                               : status
// The slave modport is the arbiter's view; master is the environment
// (clients plus list engine) that surrounds it.
interface linked_list_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_NODE   = 8
);
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1);
  localparam int ID_WIDTH   = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [3*NUM_REQ-1:0]          req_op;
  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr;
  logic [DATA_WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;

  logic                          resp_valid;
  logic [ID_WIDTH-1:0]           resp_id;
  logic [DATA_WIDTH-1:0]         resp_data;
  logic                          resp_fault;

  logic [2:0]                    ll_op;
  logic [ADDR_WIDTH-1:0]         ll_addr;
  logic [DATA_WIDTH-1:0]         ll_data;
  logic                          ll_op_start;
  logic                          ll_op_done;
  logic [DATA_WIDTH-1:0]         ll_data_out;
  logic                          ll_fault;

  logic                          busy;
  logic                          wdog_err;

  modport slave (
    input  req_valid, req_lock, req_op, req_addr, req_data,
    output req_ready,
    output resp_valid, resp_id, resp_data, resp_fault,
    output ll_op, ll_addr, ll_data, ll_op_start,
    input  ll_op_done, ll_data_out, ll_fault,
    output busy, wdog_err
  );

  modport master (
    output req_valid, req_lock, req_op, req_addr, req_data,
    input  req_ready,
    input  resp_valid, resp_id, resp_data, resp_fault,
    input  ll_op, ll_addr, ll_data, ll_op_start,
    output ll_op_done, ll_data_out, ll_fault,
    input  busy, wdog_err
  );
endinterface

// File: rtl/linked_list_arbiter.sv
// Round-robin arbiter (with optional lock) sharing one linked-list engine among NUM_REQ clients.
// Latency: accept in cycle 0, ll_op_start from cycle 1, resp_valid one cycle after ll_op_done.
// Backpressure: one op in flight; req_valid is only looked at in IDLE, grant is a req_ready pulse.
//
// Ports: clk, rst (async, active-high) plus bus (linked_list_arbiter_if.slave):
//   requests in (req_*), one-hot req_ready out, tagged response out (resp_*),
//   list command out (ll_op/addr/data/op_start), list completion in (ll_op_done/data_out/fault),
//   busy (not IDLE) and sticky wdog_err.
module linked_list_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_NODE    = 8,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  linked_list_arbiter_if.slave bus
);
  localparam int ADDR_WIDTH = $clog2(MAX_NODE + 1);
  localparam int ID_WIDTH   = $clog2(NUM_REQ);
  localparam int WDOG_WIDTH = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [ID_WIDTH-1:0]     rr_ptr_q, lock_owner_q, gid_q, grant_id;
  logic                    lock_vld_q, lock_hit, any_valid, accept;
  logic [2:0]              sel_op, op_q;
  logic [ADDR_WIDTH-1:0]   sel_addr, addr_q;
  logic [DATA_WIDTH-1:0]   sel_data, data_q, resp_data_q;
  logic                    sel_lock, resp_fault_q;
  logic [WDOG_WIDTH-1:0]   wdog_cnt_q;
  logic                    wdog_err_q;

  // (base + offs) mod NUM_REQ, offs < NUM_REQ
  function automatic logic [ID_WIDTH-1:0] rr_index(input logic [ID_WIDTH-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return ID_WIDTH'(sum);
  endfunction

  // Grant selection and request field mux. A lock only wins while its owner
  // still asserts req_valid; otherwise plain round-robin from rr_ptr applies.
  always_comb begin
    any_valid = |bus.req_valid;
    lock_hit  = lock_vld_q && bus.req_valid[lock_owner_q];
    accept    = (state_q == IDLE) && any_valid;
    grant_id  = lock_owner_q;
    if (!lock_hit) begin
      grant_id = rr_ptr_q;
      // Scan from the far end so the nearest valid at/after rr_ptr is assigned last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (bus.req_valid[rr_index(rr_ptr_q, k)]) grant_id = rr_index(rr_ptr_q, k);
      end
    end
    sel_op   = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_lock = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_id == ID_WIDTH'(k)) begin
        sel_op   = bus.req_op[3*k +: 3];
        sel_addr = bus.req_addr[ADDR_WIDTH*k +: ADDR_WIDTH];
        sel_data = bus.req_data[DATA_WIDTH*k +: DATA_WIDTH];
        sel_lock = bus.req_lock[k];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: the list cannot be aborted, so ISSUE waits for ll_op_done forever.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = ISSUE;
      ISSUE:   if (bus.ll_op_done) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs. req_ready is gated by rst so nothing is granted while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (accept && !rst) bus.req_ready = NUM_REQ'(1) << grant_id;
    bus.ll_op_start = (state_q == ISSUE);
    bus.resp_valid  = (state_q == RESP);
    bus.busy        = (state_q != IDLE);
    bus.ll_op       = op_q;
    bus.ll_addr     = addr_q;
    bus.ll_data     = data_q;
    bus.resp_id     = gid_q;
    bus.resp_data   = resp_data_q;
    bus.resp_fault  = resp_fault_q;
    bus.wdog_err    = wdog_err_q;
  end

  // Request latch, arbitration state, response capture and watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      lock_owner_q <= '0;
      lock_vld_q   <= 1'b0;
      gid_q        <= '0;
      op_q         <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
      wdog_cnt_q   <= '0;
      wdog_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        gid_q        <= grant_id;
        op_q         <= sel_op;
        addr_q       <= sel_addr;
        data_q       <= sel_data;
        rr_ptr_q     <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        lock_owner_q <= grant_id;
        lock_vld_q   <= sel_lock;
      end else if (state_q == IDLE) begin
        // Idle with no requests means the owner dropped valid: release.
        lock_vld_q <= 1'b0;
      end

      if (state_q == ISSUE && bus.ll_op_done) begin
        resp_data_q  <= bus.ll_data_out;
        resp_fault_q <= bus.ll_fault;
      end

      // Counter restarts for every op; it saturates so wdog_err fires once.
      if (state_q != ISSUE) begin
        wdog_cnt_q <= '0;
      end else if (!bus.ll_op_done && wdog_cnt_q != WDOG_WIDTH'(WDOG_CYCLES)) begin
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
        if (wdog_cnt_q == WDOG_WIDTH'(WDOG_CYCLES - 1)) wdog_err_q <= 1'b1;
      end
    end
  end
endmodule
